// File: rtl/chan_scan_pkg.sv
// Shared constants and state encoding for the channel scan sequencer.
package chan_scan_pkg;
   localparam int NCH   = 8;
   localparam int SEL_W = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      DWELL   = 2'd2
   } scan_state_t;
endpackage

// File: rtl/chan_next_find.sv
// Combinational search for the lowest enabled channel and the next enabled channel above cur.
module chan_next_find
   import chan_scan_pkg::*;
(
   input  logic [NCH-1:0]   mask,
   input  logic [SEL_W-1:0] cur,
   output logic [SEL_W-1:0] nxt,
   output logic             wrapped,
   output logic [SEL_W-1:0] first,
   output logic             any
);

   always_comb begin
      nxt     = '0;
      wrapped = 1'b1;
      first   = '0;
      any     = |mask;
      // Descending scans so the lowest qualifying bit is written last.
      for (int i = NCH - 1; i >= 0; i--) begin
         if (mask[i]) first = SEL_W'(i);
      end
      for (int i = NCH - 1; i >= 0; i--) begin
         if (mask[i] && (i > int'(cur))) begin
            nxt     = SEL_W'(i);
            wrapped = 1'b0;
         end
      end
      if (wrapped) nxt = first;
   end

endmodule

// File: rtl/chan_scan_seq.sv
// Channel scan sequencer: presents enabled channel indices via valid/ready, then holds each for a dwell window.
module chan_scan_seq
   import chan_scan_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               cont,
   input  logic [NCH-1:0]     ch_mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic [SEL_W-1:0]   sel,
   output logic               sel_valid,
   input  logic               sel_ready,
   output logic               active,
   output logic               busy,
   output logic               done,
   output logic               wrap
);

   scan_state_t        state, state_n;
   logic [DWELL_W-1:0] cnt, cnt_n;
   logic [DWELL_W-1:0] dwell_q;
   logic [NCH-1:0]     mask_q;
   logic               cont_q;
   logic [SEL_W-1:0]   sel_n;
   logic               done_n, wrap_n, adv, load;

   logic [NCH-1:0]     find_mask;
   logic [SEL_W-1:0]   nxt, first;
   logic               wrapped, any;

   // In IDLE the finder looks at the live mask so the start load needs no extra cycle.
   assign find_mask = (state == IDLE) ? ch_mask : mask_q;
   assign load      = (state == IDLE) && start && !stop && any;

   chan_next_find u_find (
      .mask    (find_mask),
      .cur     (sel),
      .nxt     (nxt),
      .wrapped (wrapped),
      .first   (first),
      .any     (any)
   );

   always_comb begin
      state_n = state;
      sel_n   = sel;
      cnt_n   = cnt;
      done_n  = 1'b0;
      wrap_n  = 1'b0;
      adv     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (any) begin
                  sel_n   = first;
                  state_n = PRESENT;
               end else begin
                  done_n = 1'b1;
               end
            end
         end
         PRESENT: begin
            if (sel_ready) begin
               if (dwell_q != '0) begin
                  cnt_n   = dwell_q;
                  state_n = DWELL;
               end else begin
                  adv = 1'b1;
               end
            end
         end
         DWELL: begin
            cnt_n = cnt - DWELL_W'(1);
            if (cnt == DWELL_W'(1)) adv = 1'b1;
         end
         default: state_n = IDLE;
      endcase

      if (adv) begin
         if (wrapped && !cont_q) begin
            done_n  = 1'b1;
            state_n = IDLE;
         end else begin
            sel_n   = nxt;
            wrap_n  = wrapped;
            state_n = PRESENT;
         end
      end

      if (stop) begin
         state_n = IDLE;
         sel_n   = sel;
         cnt_n   = '0;
         done_n  = 1'b0;
         wrap_n  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         sel       <= '0;
         sel_valid <= 1'b0;
         active    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         wrap      <= 1'b0;
         mask_q    <= '0;
         dwell_q   <= '0;
         cont_q    <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         sel       <= sel_n;
         sel_valid <= (state_n == PRESENT);
         active    <= (state_n == DWELL);
         busy      <= (state_n != IDLE);
         done      <= done_n;
         wrap      <= wrap_n;
         if (load) begin
            mask_q  <= ch_mask;
            dwell_q <= dwell;
            cont_q  <= cont;
         end
      end
   end

endmodule

// File: tb/tb_chan_scan_seq.sv
// Directed bench for chan_scan_seq: each task drives one scenario and checks cycle-exact outputs.
module tb_chan_scan_seq;
   import chan_scan_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0, stop = 1'b0, cont = 1'b0, sel_ready = 1'b0;
   logic [NCH-1:0]   ch_mask = '0;
   logic [7:0]       dwell = '0;
   logic [SEL_W-1:0] sel;
   logic             sel_valid, active, busy, done, wrap;

   int n_checks = 0;
   int n_fail   = 0;

   chan_scan_seq #(.DWELL_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .cont      (cont),
      .ch_mask   (ch_mask),
      .dwell     (dwell),
      .sel       (sel),
      .sel_valid (sel_valid),
      .sel_ready (sel_ready),
      .active    (active),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle; checks after tick see the post-edge state.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_checks++;
      if ({sel, sel_valid, active, busy, done, wrap} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs got=%h want=00", {sel, sel_valid, active, busy, done, wrap});
      end
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy=%b want=0", busy); end
   endtask

   task automatic test_single_pass();
      logic [SEL_W-1:0] chs [3] = '{3'd2, 3'd5, 3'd7};
      ch_mask = 8'b1010_0100; dwell = 8'd3; cont = 1'b0; sel_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         n_checks++;
         if (sel !== chs[c] || sel_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL single_present[%0d] sel=%0d v=%b busy=%b done=%b act=%b want sel=%0d v=1 busy=1 done=0 act=0",
                     c, sel, sel_valid, busy, done, active, chs[c]);
         end
         tick();
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (active !== 1'b1 || sel_valid !== 1'b0 || sel !== chs[c] || done !== 1'b0) begin
               n_fail++;
               $display("FAIL single_dwell[%0d.%0d] act=%b v=%b sel=%0d done=%b want act=1 v=0 sel=%0d done=0",
                        c, k, active, sel_valid, sel, done, chs[c]);
            end
            tick();
         end
      end
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || sel_valid !== 1'b0 || active !== 1'b0 || sel !== 3'd7) begin
         n_fail++;
         $display("FAIL single_done done=%b busy=%b v=%b act=%b sel=%0d want done=1 busy=0 v=0 act=0 sel=7",
                  done, busy, sel_valid, active, sel);
      end
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done_pulse done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_back_to_back();
      ch_mask = 8'hFF; dwell = 8'd0; cont = 1'b1; sel_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (sel !== SEL_W'(i) || sel_valid !== 1'b1 || wrap !== 1'b0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_sel[%0d] sel=%0d v=%b wrap=%b act=%b want sel=%0d v=1 wrap=0 act=0",
                     i, sel, sel_valid, wrap, active, i);
         end
         tick();
      end
      n_checks++;
      if (sel !== 3'd0 || wrap !== 1'b1 || sel_valid !== 1'b1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_wrap sel=%0d wrap=%b v=%b done=%b want sel=0 wrap=1 v=1 done=0", sel, wrap, sel_valid, done);
      end
      tick();
      n_checks++;
      if (sel !== 3'd1 || wrap !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_after_wrap sel=%0d wrap=%b want sel=1 wrap=0", sel, wrap);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || sel_valid !== 1'b0 || wrap !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_stop busy=%b v=%b wrap=%b done=%b want 0 0 0 0", busy, sel_valid, wrap, done);
      end
      // Single enabled channel in continuous mode wraps on every pass.
      ch_mask = 8'b0100_0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (sel !== 3'd6 || wrap !== 1'b0 || sel_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL onebit_first sel=%0d wrap=%b v=%b want sel=6 wrap=0 v=1", sel, wrap, sel_valid);
      end
      for (int p = 0; p < 2; p++) begin
         tick();
         n_checks++;
         if (sel !== 3'd6 || wrap !== 1'b1 || sel_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL onebit_wrap[%0d] sel=%0d wrap=%b v=%b want sel=6 wrap=1 v=1", p, sel, wrap, sel_valid);
         end
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      cont = 1'b0;
   endtask

   task automatic test_ready_stall();
      ch_mask = 8'b0001_0000; dwell = 8'd2; cont = 1'b0; sel_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (sel !== 3'd4 || sel_valid !== 1'b1 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL stall[%0d] sel=%0d v=%b act=%b want sel=4 v=1 act=0", i, sel, sel_valid, active);
         end
         tick();
      end
      sel_ready = 1'b1;
      tick();
      n_checks++;
      if (active !== 1'b1 || sel_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_accept act=%b v=%b want act=1 v=0", active, sel_valid);
      end
      tick();
      tick();
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || active !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_done done=%b busy=%b act=%b want 1 0 0", done, busy, active);
      end
      tick();
   endtask

   task automatic test_empty_and_conflict();
      ch_mask = 8'h00; start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || sel_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_done done=%b busy=%b v=%b want 1 0 0", done, busy, sel_valid);
      end
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_pulse done=%b busy=%b want 0 0", done, busy);
      end
      ch_mask = 8'h0F; start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || sel_valid !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
         n_fail++;
         $display("FAIL start_stop busy=%b v=%b done=%b wrap=%b want 0 0 0 0", busy, sel_valid, done, wrap);
      end
      tick();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL start_stop_after busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_stop_dwell();
      ch_mask = 8'b0100_1001; dwell = 8'd3; cont = 1'b0; sel_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick(); tick();
      n_checks++;
      if (sel !== 3'd3 || sel_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL stopdw_ch3 sel=%0d v=%b want sel=3 v=1", sel, sel_valid);
      end
      tick();
      tick();
      n_checks++;
      if (active !== 1'b1 || sel !== 3'd3) begin
         n_fail++;
         $display("FAIL stopdw_second act=%b sel=%0d want act=1 sel=3", active, sel);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_checks++;
      if (active !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sel_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stopdw_idle act=%b busy=%b done=%b v=%b want 0 0 0 0", active, busy, done, sel_valid);
      end
      tick(); tick(); tick();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL stopdw_stays busy=%b done=%b want 0 0", busy, done);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (sel !== 3'd0 || sel_valid !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL stopdw_restart sel=%0d v=%b busy=%b want sel=0 v=1 busy=1", sel, sel_valid, busy);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic test_async_reset();
      ch_mask = 8'b0010_0000; dwell = 8'd5; cont = 1'b1; sel_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      n_checks++;
      if (active !== 1'b1 || sel !== 3'd5) begin
         n_fail++;
         $display("FAIL arst_pre act=%b sel=%0d want act=1 sel=5", active, sel);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({sel, sel_valid, active, busy, done, wrap} !== 8'h00) begin
         n_fail++;
         $display("FAIL arst_mid got=%h want=00", {sel, sel_valid, active, busy, done, wrap});
      end
      tick();
      rst_n = 1'b1;
      tick(); tick();
      n_checks++;
      if (busy !== 1'b0 || active !== 1'b0 || sel_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL arst_no_resume busy=%b act=%b v=%b want 0 0 0", busy, active, sel_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_back_to_back();
      test_ready_stall();
      test_empty_and_conflict();
      test_stop_dwell();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/chan_scan_seq.md
# chan_scan_seq

Channel scan sequencer that sits directly upstream of the 3-to-8 select decoder. It walks an 8-bit channel enable mask in ascending order and presents each enabled channel's 3-bit index on `sel` through a valid/ready handshake. After each accepted index it holds `sel` stable for a programmable dwell period, so the decoder's one-hot output stays steady while the channel is serviced. It supports a single pass or continuous scanning, plus synchronous abort.

## Interface
- `DWELL_W`, default 8: width of the dwell count.
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: begin a scan; sampled only in IDLE.
- `stop` input 1: synchronous abort; takes effect from any state.
- `cont` input 1: scan mode, 1 = continuous, 0 = single pass; latched at start.
- `ch_mask` input 8: channel enables, bit i = channel i; latched at start.
- `dwell` input DWELL_W: hold cycles after acceptance; latched at start.
- `sel` output 3: current channel index, fed to the decoder select.
- `sel_valid` output 1: `sel` offered to downstream.
- `sel_ready` input 1: downstream accepts `sel`.
- `active` output 1: `sel` accepted and inside its dwell window.
- `busy` output 1: scan in progress (not IDLE).
- `done` output 1: one-cycle pulse at the end of a single pass, or when start is given with an empty mask.
- `wrap` output 1: one-cycle pulse when a continuous scan wraps from its highest to its lowest enabled channel.

## Operation
- States are IDLE, PRESENT and DWELL.
- IDLE:
  - `busy` = `sel_valid` = `active` = 0.
  - `start` with `ch_mask` != 0: latch mask, dwell and mode; load `sel` with the lowest set bit; go to PRESENT.
  - `start` with `ch_mask` == 0: pulse `done`, stay in IDLE.
- PRESENT:
  - `sel_valid` = 1; `sel` is held until accepted.
  - On `sel_valid` && `sel_ready` with dwell > 0: load the counter with dwell and go to DWELL.
  - On acceptance with dwell == 0: advance immediately.
- DWELL:
  - `active` = 1, `sel_valid` = 0, `sel` unchanged.
  - The counter decrements each cycle; when it reaches 1, advance at the end of that cycle.
- Advance:
  - Next index is the next set bit strictly above `sel` in the latched mask.
  - If no set bit lies above `sel`, it wraps to the lowest set bit.
  - Wrap in single mode: pulse `done`, go to IDLE, `sel` keeps its last value.
  - Wrap in continuous mode: pulse `wrap`, go to PRESENT with the wrapped index.
  - No wrap: go to PRESENT with the next index.
- Single-bit mask in continuous mode: the same index is re-presented on every pass, with a `wrap` pulse each time.
- `stop`:
  - From any state, the next state is IDLE, with `sel_valid` and `active` cleared.
  - No `done` and no `wrap` pulse.
  - `stop` has priority over `start` and over an advance in the same cycle.
- `start` while busy is ignored. Changes to `ch_mask`, `dwell` or `cont` mid-scan have no effect until the next start.
- Dwell counter arithmetic is unsigned in DWELL_W bits; a dwell of 2^DWELL_W−1 is legal.

## Timing
- Reset values: `sel`=0, `sel_valid`=0, `active`=0, `busy`=0, `done`=0, `wrap`=0; state IDLE, counter 0.
- All outputs are registered.
- `start` sampled at edge N: `sel_valid` and `busy` are high from cycle N+1.
- Acceptance at edge A with dwell D > 0:
  - `active` is high for exactly D cycles, A+1 to A+D.
  - The next index appears with `sel_valid` high at A+D+1.
- Acceptance at edge A with D = 0: the next index has `sel_valid` high at A+1, giving back-to-back presentation.
- End of pass:
  - `done` and `wrap` are high only during the cycle in which the next presentation would begin.
  - For a single-pass end, that cycle is A+D+1 and `busy` is 0 in it.
- `stop` sampled at edge S: `busy`, `sel_valid` and `active` are 0 from cycle S+1.
- Asynchronous reset mid-scan: all outputs go to their reset values immediately. Operation resumes only on a new `start` after reset is released.

## Structure
- Package `chan_scan_pkg`: `NCH`=8, `SEL_W`=3, and the state enum `scan_state_t` {IDLE, PRESENT, DWELL}.
- Sub-module `chan_next_find` (combinational):
  - Inputs: mask[7:0], cur[2:0].
  - Outputs: `nxt[2:0]`, `wrapped`, `first[2:0]`, `any`.
  - Used both for the start load and for every advance.
- Top level holds the FSM, the dwell counter and the latched configuration registers.

## Test plan
- Mask 8'b1010_0100, dwell 3, single mode, `sel_ready` held 1 → `sel` = 2, 5, 7; each index followed by 3 `active` cycles; `done` pulses once; `busy` then drops.
- Mask 8'hFF, dwell 0, continuous, `sel_ready` held 1 → `sel` counts 0..7 on consecutive cycles; `wrap` pulses on the cycle `sel` returns to 0.
- Mask 8'b0001_0000, `sel_ready` low for 5 cycles → `sel` = 4 held with `sel_valid` high throughout; no `active` until ready rises.
- `start` with mask 0 → single `done` pulse, `busy` stays 0; `start` and `stop` in the same cycle → stays IDLE, no pulses.
- `stop` in the second DWELL cycle of channel 3 → `active` and `busy` are 0 in the next cycle, no `done`; a fresh `start` rescans from the lowest enabled channel.
- `rst_n` asserted mid-DWELL, asynchronously between edges → all outputs reset before the next edge.
